// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter with one-shot or auto-reload mode and terminal-count pulse
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, rl_q, rl_d;
  logic tc_q, tc_d, busy_q, busy_d;
  logic at_one;
  assign at_one = q_q <= WIDTH'(1);
  // next-state: load wins, otherwise count down while running and enabled
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    rl_d = rl_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = load_val;
      rl_d = load_val;
      state_d = load_val != '0 ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      q_d = !at_one ? q_q - 1'b1 : (reload ? rl_q : '0);
      tc_d = at_one;
      state_d = at_one && !reload ? IDLE : RUN;
    end
    busy_d = state_d == RUN;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q <= '0;
      rl_q <= '0;
      tc_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      rl_q <= rl_d;
      tc_q <= tc_d;
      busy_q <= busy_d;
    end
  end
  assign Q = q_q;
  assign tc = tc_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: scoreboard bench for sync_down_counter against a count/remaining-value model
module tb_sync_down_counter;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, en = 1'b0, reload = 1'b0;
  logic [W-1:0] load_val = '0, q;
  logic tc, busy;
  int n_checks = 0, n_fail = 0;
  typedef struct {int q; bit tc; bit busy; string tag;} exp_t;
  exp_t sb[$];
  int m_cnt = 0, m_rl = 0;
  bit m_run = 1'b0;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .en(en), .reload(reload), .Q(q), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // monitor: compare DUT outputs just after each rising edge against the queued expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".Q"}, int'(q), e.q);
      chk({e.tag, ".tc"}, int'(tc), int'(e.tc));
      chk({e.tag, ".busy"}, int'(busy), int'(e.busy));
    end
  end

  // one clock of stimulus; the model decides what the counter shows after the edge
  task automatic cyc(input bit ld, input int lv, input bit e, input bit rel, input string tag);
    exp_t x;
    bit t;
    @(negedge clk);
    load = ld; load_val = W'(lv); en = e; reload = rel;
    t = 1'b0;
    if (ld) begin
      m_cnt = lv; m_rl = lv; m_run = lv != 0;
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        t = 1'b1;
        if (rel) m_cnt = m_rl;
        else begin m_cnt = 0; m_run = 1'b0; end
      end else m_cnt = m_cnt - 1;
    end
    x.q = m_cnt; x.tc = t; x.busy = m_run; x.tag = tag;
    sb.push_back(x);
  endtask

  // asynchronous reset pulse between edges, checked immediately
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".Q"}, int'(q), 0);
    chk({tag, ".tc"}, int'(tc), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    reset = 1'b0;
    m_cnt = 0; m_rl = 0; m_run = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.Q", int'(q), 0);
    chk("reset.tc", int'(tc), 0);
    chk("reset.busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 5, 1, 0, "oneshot_load");
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, "oneshot_run");
    cyc(1, 3, 1, 1, "reload_load");
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, "reload_run");
    cyc(1, 4, 1, 0, "en_load");
    for (int i = 0; i < 4; i++) cyc(0, 0, i[0] == 1'b0, 0, "en_toggle");
    cyc(1, 2, 1, 0, "race_load");
    cyc(0, 0, 1, 0, "race_to1");
    cyc(1, 7, 1, 0, "race_loadwins");
    cyc(0, 0, 1, 0, "race_after");
    cyc(1, 8, 1, 0, "abort_load");
    cyc(0, 0, 1, 0, "abort_7");
    cyc(0, 0, 1, 0, "abort_6");
    pulse_reset("abort_reset");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, "abort_idle");
    cyc(1, 0, 1, 1, "zero_load");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, "zero_idle");
    cyc(1, 15, 1, 0, "max_load");
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, "max_run");
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1), "random");
    pulse_reset("final_reset");
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  load request, sampled on rising clk.
REQ-005 SHALL have port load_val  input  WIDTH  start and reload value captured on load.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port reload  input  1  mode: 1 = auto-reload at terminal count, 0 = one-shot.
REQ-008 SHALL have port Q  output  WIDTH  current count, registered.
REQ-009 SHALL have port tc  output  1  terminal-count pulse, registered.
REQ-010 SHALL have port busy  output  1  high while in RUN state, registered.

Function
REQ-011 SHALL implement two states, IDLE and RUN; busy = 1 exactly when state = RUN.
REQ-012 SHALL hold an internal WIDTH-bit reload register rl, written only on load.
REQ-013 Load SHALL take priority over all other activity: on an edge with load=1, Q <= load_val, rl <= load_val, and tc <= 0.
REQ-014 On load with load_val != 0, state SHALL become RUN; with load_val = 0, state SHALL become IDLE.
REQ-015 In RUN with en=1, load=0 and Q > 1, Q SHALL decrement by 1 per edge; tc <= 0.
REQ-016 In RUN with en=1, load=0, Q = 1 and reload=0, the edge SHALL set Q <= 0, tc <= 1, and state <= IDLE.
REQ-017 In RUN with en=1, load=0, Q = 1 and reload=1, the edge SHALL set Q <= rl, tc <= 1, and state stays RUN.
REQ-018 Auto-reload period SHALL therefore be exactly rl enabled cycles per tc pulse.
REQ-019 tc SHALL be high for exactly one clk cycle per terminal count and 0 on every other edge.
REQ-020 In RUN with en=0 and load=0, Q and state SHALL hold and tc <= 0.
REQ-021 In IDLE without load, Q SHALL hold regardless of en, with no wrap below 0, and tc <= 0.
REQ-022 reload SHALL be sampled only at the Q = 1 edge; changing it mid-count SHALL affect only that decision.
REQ-023 Q SHALL never take a value outside 0..rl after a load; no underflow wrap SHALL occur.

Reset
REQ-024 Assertion of reset SHALL immediately, independent of clk, set Q = 0, rl = 0, tc = 0, busy = 0, and state = IDLE.
REQ-025 Reset asserted mid-count SHALL abort the count with no tc pulse; the block SHALL stay IDLE after release until the next load.
REQ-026 On the first rising edge after reset deassertion, normal operation SHALL begin, with load honoured on that edge.

Verification
REQ-027 Reset, then load=1 with load_val=5, reload=0, en=1 held -> Q sequence 5,4,3,2,1,0; tc high only in the cycle where Q=0; busy falls with it; Q stays 0.
REQ-028 WIDTH=4, load_val=3, reload=1, en=1 for 9 cycles -> Q sequence 3,2,1,3,2,1,3,2,1; tc pulses every 3rd cycle coincident with Q=3 after the reload; busy stays 1.
REQ-029 load_val=4, en toggling 1,0,1,0 -> Q decrements only on en=1 edges (4,3,3,2,2); tc stays 0.
REQ-030 Q=1, en=1, and load=1 with load_val=7 on the same edge -> Q=7, tc=0, busy=1 (load wins).
REQ-031 Reset pulsed asynchronously between edges while Q=6 in RUN -> Q=0, busy=0, tc=0 immediately; en=1 after release with no load -> Q stays 0.
REQ-032 load with load_val=0 -> Q=0, busy=0, tc never asserted.
